// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared types for the fetch sequencer.
// States, opcodes and the instruction-register layout.
package fetch_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_FETCH     = 3'd1;
  localparam state_t S_DECODE    = 3'd2;
  localparam state_t S_EXECUTE   = 3'd3;
  localparam state_t S_WRITEBACK = 3'd4;
  localparam state_t S_HALT      = 3'd5;
  localparam state_t S_ERROR     = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [3:0] addr1;
    logic [3:0] addr2;
    logic [7:0] word;
  } ir_t;

endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: instruction-memory and datapath bus of the sequencer.
// master = sequencer side, slave = memory/datapath side.
interface fetch_seq_if #(
  parameter int PC_W = 4
);
  logic [PC_W-1:0] read_add;
  logic [3:0]      ins_addr1;
  logic [3:0]      ins_addr2;
  logic [3:0]      ins_ctrl;
  logic [7:0]      ins_word;
  logic            zero_flag;
  logic            exe_done;
  logic [3:0]      rf_rd_addr1;
  logic [3:0]      rf_rd_addr2;
  logic [3:0]      alu_op;
  logic [7:0]      imm;
  logic            exe_req;
  logic            rf_wr_en;
  logic [3:0]      rf_wr_addr;
  logic            busy;
  logic            halted;
  logic            err;

  modport master (
    output read_add, rf_rd_addr1, rf_rd_addr2,
    output alu_op, imm, exe_req,
    output rf_wr_en, rf_wr_addr,
    output busy, halted, err,
    input  ins_addr1, ins_addr2, ins_ctrl,
    input  ins_word, zero_flag, exe_done
  );

  modport slave (
    input  read_add, rf_rd_addr1, rf_rd_addr2,
    input  alu_op, imm, exe_req,
    input  rf_wr_en, rf_wr_addr,
    input  busy, halted, err,
    output ins_addr1, ins_addr2, ins_ctrl,
    output ins_word, zero_flag, exe_done
  );

endinterface

// File: rtl/fetch_sequencer_watchdog.sv
// exe_watchdog: counts EXECUTE cycles, flags the last allowed one.
// expire is high in the EXE_TIMEOUT-th enabled cycle after a clear.
module exe_watchdog #(
  parameter int EXE_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(EXE_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign expire = en && (cnt_q == CW'(EXE_TIMEOUT - 1));

  // count enabled cycles, hold once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (en && !expire)
      cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode/execute/writeback control.
// Define FETCH_SEQ_BRANCH_EN to enable the BZ/JMP opcodes.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int              PC_W        = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              EXE_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  fetch_seq_if.master  bus
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  ir_t             ir_q;
  logic            op_alu;
  logic            wd_expire;

  assign pc_inc = pc_q + PC_W'(1);
  assign op_alu = (ir_q.ctrl >= 4'h1) &&
                  (ir_q.ctrl <= 4'hC);

`ifdef FETCH_SEQ_BRANCH_EN
  logic [PC_W-1:0] tgt;
  assign tgt = ir_q.word[PC_W-1:0];
`else
  logic unused_zero;
  assign unused_zero = bus.zero_flag;
`endif

  exe_watchdog #(
    .EXE_TIMEOUT (EXE_TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (state_q != S_EXECUTE),
    .en     (state_q == S_EXECUTE),
    .expire (wd_expire)
  );

  // next-state and next-PC selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          ir_q.ctrl == OP_HALT:
            state_d = S_HALT;
          op_alu:
            state_d = S_EXECUTE;
`ifdef FETCH_SEQ_BRANCH_EN
          ir_q.ctrl == OP_JMP: begin
            state_d = S_FETCH;
            pc_d    = tgt;
          end
          ir_q.ctrl == OP_BZ: begin
            state_d = S_FETCH;
            pc_d    = bus.zero_flag ? tgt : pc_inc;
          end
`endif
          default: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
          end
        endcase
      end
      S_EXECUTE: begin
        if (bus.exe_done)
          state_d = S_WRITEBACK;
        else if (wd_expire)
          state_d = S_ERROR;
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // state, PC and instruction register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_FETCH)
        ir_q <= '{ctrl:  bus.ins_ctrl,
                  addr1: bus.ins_addr1,
                  addr2: bus.ins_addr2,
                  word:  bus.ins_word};
    end
  end

  assign bus.read_add    = pc_q;
  assign bus.rf_rd_addr1 = ir_q.addr1;
  assign bus.rf_rd_addr2 = ir_q.addr2;
  assign bus.alu_op      = ir_q.ctrl;
  assign bus.imm         = ir_q.word;
  assign bus.rf_wr_addr  = ir_q.addr1;
  assign bus.exe_req     = state_q == S_EXECUTE;
  assign bus.rf_wr_en    = state_q == S_WRITEBACK;
  assign bus.halted      = state_q == S_HALT;
  assign bus.err         = state_q == S_ERROR;
  assign bus.busy        = (state_q == S_FETCH)   ||
                           (state_q == S_DECODE)  ||
                           (state_q == S_EXECUTE) ||
                           (state_q == S_WRITEBACK);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of the fetch sequencer.
// Memory and exe_done responder are modelled in the bench.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic zero = 1'b0;
  int   done_at = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ir_t  mem [16];
  logic [7:0] ex_cnt;
  logic found;

  fetch_seq_if #(.PC_W(4)) bus ();

  fetch_sequencer #(
    .PC_W        (4),
    .RESET_PC    (4'h0),
    .EXE_TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.ins_ctrl  = mem[bus.read_add].ctrl;
  assign bus.ins_addr1 = mem[bus.read_add].addr1;
  assign bus.ins_addr2 = mem[bus.read_add].addr2;
  assign bus.ins_word  = mem[bus.read_add].word;
  assign bus.zero_flag = zero;
  assign bus.exe_done  = bus.exe_req && (done_at != 0) &&
                         (int'(ex_cnt) == done_at - 1);

  // cycles spent so far in the current execute request
  always @(posedge clk or negedge rst) begin
    if (!rst)
      ex_cnt <= '0;
    else if (bus.exe_req)
      ex_cnt <= ex_cnt + 8'd1;
    else
      ex_cnt <= '0;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++)
      mem[i] = '0;
  endtask

  initial begin
    clear_mem();
    // reset with start held: nothing may move
    start = 1'b1;
    step(2);
    check("rst_read_add", bus.read_add, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_err", bus.err, 0);
    check("rst_exe_req", bus.exe_req, 0);
    check("rst_wr_en", bus.rf_wr_en, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_imm", bus.imm, 0);
    start = 1'b0;
    rst = 1'b1;
    step(1);
    check("idle_busy", bus.busy, 0);

    // ALU instruction with exe_done on the 3rd EXECUTE cycle
    mem[0] = '{ctrl: 4'h1, addr1: 4'h3, addr2: 4'h5, word: 8'h35};
    mem[1] = '{ctrl: OP_HALT, addr1: 4'h0, addr2: 4'h0, word: 8'h00};
    done_at = 3;
    pulse_start();
    check("alu_fetch_pc", bus.read_add, 0);
    check("alu_fetch_busy", bus.busy, 1);
    step(1);
    check("alu_rd1", bus.rf_rd_addr1, 3);
    check("alu_rd2", bus.rf_rd_addr2, 5);
    check("alu_op", bus.alu_op, 1);
    check("alu_imm", bus.imm, 8'h35);
    step(1);
    check("alu_ex1_req", bus.exe_req, 1);
    step(1);
    check("alu_ex2_req", bus.exe_req, 1);
    check("alu_ex2_wr", bus.rf_wr_en, 0);
    step(1);
    check("alu_ex3_req", bus.exe_req, 1);
    step(1);
    check("alu_wb_en", bus.rf_wr_en, 1);
    check("alu_wb_addr", bus.rf_wr_addr, 3);
    check("alu_wb_req", bus.exe_req, 0);
    check("alu_wb_op", bus.alu_op, 1);
    step(1);
    check("alu_next_pc", bus.read_add, 1);
    check("alu_next_wr", bus.rf_wr_en, 0);
    step(2);
    check("halt1_halted", bus.halted, 1);
    check("halt1_pc", bus.read_add, 1);
    check("halt1_busy", bus.busy, 0);

    // PC wrap through NOPs, then HALT at address 0
    clear_mem();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.read_add == 4'hF) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wrap_reach_f", found, 1);
    mem[0] = '{ctrl: OP_HALT, addr1: 4'h0, addr2: 4'h0, word: 8'h00};
    step(2);
    check("wrap_pc", bus.read_add, 0);
    step(2);
    check("wrap_halted", bus.halted, 1);
    check("wrap_halt_pc", bus.read_add, 0);
    pulse_start();
    check("restart_busy", bus.busy, 1);
    check("restart_halted", bus.halted, 0);
    check("restart_pc", bus.read_add, 0);
    step(2);
    check("rehalt", bus.halted, 1);

    // watchdog: exe_done never comes
    mem[0] = '{ctrl: 4'h2, addr1: 4'h7, addr2: 4'h1, word: 8'h00};
    mem[1] = '{ctrl: OP_HALT, addr1: 4'h0, addr2: 4'h0, word: 8'h00};
    done_at = 0;
    pulse_start();
    step(16);
    check("wd_ex15_req", bus.exe_req, 1);
    check("wd_ex15_err", bus.err, 0);
    step(1);
    check("wd_err", bus.err, 1);
    check("wd_req_low", bus.exe_req, 0);
    check("wd_busy", bus.busy, 0);
    pulse_start();
    check("wd_start_ign", bus.err, 1);
    check("wd_start_busy", bus.busy, 0);
    rst = 1'b0;
    #1;
    check("wd_rst_err", bus.err, 0);
    check("wd_rst_pc", bus.read_add, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1);

    // exe_done on the expiry cycle wins
    done_at = 15;
    pulse_start();
    step(16);
    check("sim_ex15_req", bus.exe_req, 1);
    step(1);
    check("sim_wb_en", bus.rf_wr_en, 1);
    check("sim_wb_addr", bus.rf_wr_addr, 7);
    check("sim_err", bus.err, 0);
    step(1);
    check("sim_next_pc", bus.read_add, 1);
    check("sim_err2", bus.err, 0);
    step(2);
    check("sim_halted", bus.halted, 1);

    // reset during writeback drops the strobe at once
    mem[0] = '{ctrl: 4'h3, addr1: 4'h4, addr2: 4'h2, word: 8'h00};
    done_at = 1;
    pulse_start();
    step(2);
    check("mid_ex1_req", bus.exe_req, 1);
    step(1);
    check("mid_wb_en", bus.rf_wr_en, 1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_wr", bus.rf_wr_en, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_pc", bus.read_add, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1);

    // branches
    clear_mem();
    done_at = 0;
    mem[0]    = '{ctrl: OP_JMP,  addr1: 4'h0, addr2: 4'h0, word: 8'h0A};
    mem[1]    = '{ctrl: OP_HALT, addr1: 4'h0, addr2: 4'h0, word: 8'h00};
    mem[4'hA] = '{ctrl: OP_BZ,   addr1: 4'h0, addr2: 4'h0, word: 8'h05};
    mem[4'hB] = '{ctrl: OP_BZ,   addr1: 4'h0, addr2: 4'h0, word: 8'h05};
    mem[5]    = '{ctrl: OP_HALT, addr1: 4'h0, addr2: 4'h0, word: 8'h00};
    zero = 1'b0;
    pulse_start();
    step(2);
`ifdef FETCH_SEQ_BRANCH_EN
    check("jmp_pc", bus.read_add, 4'hA);
    step(2);
    check("bz_nt_pc", bus.read_add, 4'hB);
    zero = 1'b1;
    step(2);
    check("bz_t_pc", bus.read_add, 5);
    step(2);
    check("br_halted", bus.halted, 1);
`else
    check("jmp_nop_pc", bus.read_add, 1);
    step(2);
    check("br_halted", bus.halted, 1);
    check("br_halt_pc", bus.read_add, 1);
`endif
    zero = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle controller that sequences the datapath around the combinational instruction memory. It owns the program counter, drives the memory read address, and latches the decoded fields (Addr1, Addr2, Control, Word) into an instruction register. It then steps register-file read, execute and writeback, with an execute handshake and a watchdog. It sits between the instruction memory and the register-file/ALU datapath.

## Interface
- PC_W, 4: program-counter width; matches the instruction memory's read-address width.
- RESET_PC, 0: PC value loaded on reset and on every `start`.
- EXE_TIMEOUT, 15: maximum number of EXECUTE cycles without `exe_done` before an error is flagged.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; begins execution at RESET_PC from IDLE or HALT; ignored in all other states.
- read_add  out  PC_W  current PC, driven to the instruction memory read address.
- ins_addr1  in  4  instruction field Addr1 (destination / first source).
- ins_addr2  in  4  instruction field Addr2 (second source).
- ins_ctrl  in  4  instruction field Control (opcode).
- ins_word  in  8  instruction field Word (immediate / target).
- zero_flag  in  1  ALU zero flag, sampled in DECODE.
- exe_done  in  1  execute-complete acknowledge.
- rf_rd_addr1  out  4  register-file read port 1 address.
- rf_rd_addr2  out  4  register-file read port 2 address.
- alu_op  out  4  ALU operation (latched opcode).
- imm  out  8  latched immediate.
- exe_req  out  1  execute request.
- rf_wr_en  out  1  register-file write strobe.
- rf_wr_addr  out  4  register-file write address.
- busy  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
- halted  out  1  high in HALT.
- err  out  1  sticky watchdog error.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT, ERROR.
- IDLE: `start` loads RESET_PC into the PC and moves to FETCH.
- FETCH: `read_add` = PC. At the end of the cycle the four `ins_*` fields are latched into the instruction register (IR). Next state is DECODE.
- DECODE: `rf_rd_addr1`/`rf_rd_addr2` are driven from the IR Addr1/Addr2 fields. The opcode selects the next state:
  - OP_NOP (0): PC+1, then FETCH.
  - OP_HALT (F): PC unchanged, then HALT.
  - Opcodes 1 through C: EXECUTE.
  - OP_BZ (D) and OP_JMP (E): see Configuration.
- EXECUTE: `exe_req` is held high each cycle until `exe_done` is sampled high, then the block moves to WRITEBACK. If EXE_TIMEOUT cycles pass without `exe_done`, the block moves to ERROR.
- WRITEBACK: `rf_wr_en` is pulsed for 1 cycle with `rf_wr_addr` = IR Addr1. PC becomes PC+1, then FETCH.
- PC arithmetic is modulo 2^PC_W: 4'hF + 1 wraps to 4'h0.
- HALT is sticky; only `start` (restart at RESET_PC) or reset leaves it.
- ERROR sets `err` high and `exe_req` low. It leaves only on reset; `start` is ignored.
- Reset values: PC = RESET_PC; IR = 0; every output 0 except `read_add` = RESET_PC; state = IDLE.
- Reset asserted mid-instruction: `exe_req` and `rf_wr_en` drop immediately (asynchronously). No writeback occurs.

## Timing
- Instruction latency:
  - NOP / BZ / JMP: 2 cycles (FETCH, DECODE).
  - ALU opcode: minimum 4 cycles (FETCH, DECODE, 1 EXECUTE, WRITEBACK), plus 1 cycle per additional EXECUTE cycle.
- `exe_done` is honoured in the first EXECUTE cycle. `exe_done` outside EXECUTE is ignored.
- `alu_op`, `imm`, `rf_rd_addr*` are registered from the IR and stay stable from DECODE through WRITEBACK.
- The watchdog counter clears on entry to EXECUTE. ERROR is entered at the EXECUTE cycle numbered EXE_TIMEOUT+1 if `exe_done` was never seen.
- `exe_done` high in the same cycle the watchdog expires: `exe_done` wins and the block goes to WRITEBACK.

## Configuration
- FETCH_SEQ_BRANCH_EN defined:
  - OP_JMP loads PC <= IR Word[PC_W-1:0].
  - OP_BZ loads the same target when `zero_flag`=1, else PC+1.
  - Both then go to FETCH.
- FETCH_SEQ_BRANCH_EN undefined: D and E decode as NOP (PC+1), and `zero_flag` is unused.

## Structure
- Package `fetch_seq_pkg`: the state enum and the opcode constants OP_NOP=4'h0, OP_BZ=4'hD, OP_JMP=4'hE, OP_HALT=4'hF.
- Sub-module `exe_watchdog`: cycle counter with clear, enable and expire output, parameterised by EXE_TIMEOUT.

## Test plan
- Reset: `rst`=0 at any point -> all outputs 0, `read_add`=0, state IDLE; `start` ignored while `rst`=0.
- ALU instruction: memory[0] = {ctrl=1, a1=3, a2=5, word=8'h35}, `start`, `exe_done` on 3rd EXECUTE cycle -> `rf_rd_addr1`=3, `rf_rd_addr2`=5, `rf_wr_en` pulse with `rf_wr_addr`=3, `read_add`=1, 6 cycles total.
- Wrap and halt: PC=F with NOP -> `read_add`=0 next; memory[0] ctrl=F -> `halted`=1 and PC stays 0; `start` -> FETCH at 0.
- Watchdog: `exe_done` held 0 -> `err`=1 after 15 EXECUTE cycles, `exe_req`=0; `start` ignored; reset clears `err`.
- Branch (FETCH_SEQ_BRANCH_EN defined): JMP word=8'h0A -> `read_add`=A; BZ with `zero_flag`=0 -> PC+1, with `zero_flag`=1 -> target. With the macro undefined, both behave as NOP.
- Simultaneous: `exe_done`=1 on the expiry cycle -> WRITEBACK, `err` stays 0.
